seq_multiplier: RTL

//   Parametrised sequential shift-add multiplier. Successor to the 4x4 combinational multiplier.

---
 rtl/seq_multiplier.sv | 132 +++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one operation in flight, WIDTH-cycle fixed latency,
// run-time signed/unsigned mode, valid/ready handshakes on input and output.
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     operand1,
  input  logic [WIDTH-1:0]     operand2,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   product_q, product_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic            out_valid_q, out_valid_d;

  logic            accept;
  logic            last_step;
  logic            out_fire;
  logic [WIDTH-1:0] mag1, mag2;
  logic [PW-1:0]   acc_sum;

  always_comb begin
    accept    = in_valid && (state_q == IDLE);
    last_step = (state_q == BUSY) && (cnt_q == CW'(WIDTH - 1));
    out_fire  = out_valid_q && out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (last_step) state_d = DONE;
      DONE:    if (out_fire)  state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = out_valid_q;
    product   = product_q;
  end

  // Signed operands are reduced to magnitudes; the WIDTH-bit unsigned negate of the
  // most negative value yields 2^(WIDTH-1), which is exactly the magnitude needed.
  always_comb begin
    mag1    = (signed_mode && operand1[WIDTH-1]) ? -operand1 : operand1;
    mag2    = (signed_mode && operand2[WIDTH-1]) ? -operand2 : operand2;
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          neg_d    = signed_mode && (operand1[WIDTH-1] ^ operand2[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          product_d   = neg_q ? -acc_sum : acc_sum;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      DONE: begin
        if (out_fire) out_valid_d = 1'b0;
      end
      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
